seq_arbiter: RTL and testbench
==============================

SEQ_ARBITER -- requirements
Module: seq_arbiter

Interface
REQ-001 Parameter HOLD, default 2, range 1..15: number of cycles d_ou is held high per transaction.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a_in  input  1  requester A level request.
REQ-005 b_in  input  1  requester B level request.
REQ-006 c_ou  output  1  start strobe, one cycle per transaction.
REQ-007 d_ou  output  1  active phase, high for HOLD cycles.
REQ-008 e_ou  output  1  ready/idle indicator, high only in IDLE.
REQ-009 gnt_a  output  1  requester A owns the current transaction.
REQ-010 gnt_b  output  1  requester B owns the current transaction.
REQ-011 cnt_ou  output  4  remaining active-phase cycles; 0 outside ACTIVE.

Function
REQ-012 FSM states SHALL be IDLE, START, ACTIVE and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-013 IDLE: e_ou=1, c_ou=d_ou=gnt_a=gnt_b=0; request sampled at an edge -> START at that edge; no request -> stay in IDLE.
REQ-014 Single request: the requester present at the sampling edge SHALL be granted.
REQ-015 Simultaneous a_in and b_in: grant SHALL go to the requester that did not win the last transaction; after reset A wins the first tie.
REQ-016 START lasts exactly 1 cycle: c_ou=1, e_ou=0, grant asserted; next state ACTIVE with cnt loaded to HOLD.
REQ-017 ACTIVE: d_ou=1, e_ou=0, cnt_ou decrements each cycle; cnt_ou==1 -> DONE.
REQ-018 DONE lasts exactly 1 cycle: c_ou=d_ou=0, e_ou=0, grant still asserted; the round-robin pointer updates; next state IDLE.
REQ-019 Grant SHALL be stable from START through DONE, be one-hot, and drop on entry to IDLE.
REQ-020 Request changes after the grant SHALL be ignored; a started transaction always completes.
REQ-021 Latency: request sampled at edge N -> c_ou high in cycle N+1, d_ou in cycles N+2..N+1+HOLD, e_ou low from N+1 through N+2+HOLD.
REQ-022 IDLE SHALL last at least 1 cycle between transactions; back-to-back requests restart at the edge following DONE.
REQ-023 A persistent request from both requesters SHALL alternate grants A,B,A,B...

Reset
REQ-024 On rst_n low, the block SHALL immediately enter IDLE regardless of state (including mid-transaction).
REQ-025 Reset values: c_ou=0, d_ou=0, e_ou=1, gnt_a=0, gnt_b=0, cnt_ou=0, round-robin pointer favouring A.
REQ-026 After rst_n deasserts, the first request SHALL be sampled no earlier than the first rising clk edge with rst_n high.

Configuration
REQ-027 Macro SEQ_ARB_FIXED_PRIO_EN defined: ties always go to A and the pointer is unused; undefined: round-robin per REQ-015 and REQ-023.

Verification (HOLD=2)
REQ-028 a_in=1 for one cycle from idle -> c_ou 1 cycle, d_ou 2 cycles, gnt_a for 4 cycles, e_ou=1 back in the 5th cycle.
REQ-029 a_in=b_in=1 held high for 20 cycles -> grants A,B,A,B, each transaction 4 cycles with 1 IDLE cycle between; with macro defined, grants are A only.
REQ-030 b_in pulse, then a_in raised during ACTIVE -> B transaction completes unchanged, then A is granted after IDLE.
REQ-031 rst_n low during ACTIVE (cnt_ou=1) -> asynchronously c_ou=d_ou=0, e_ou=1, gnts=0, cnt_ou=0; after release, a tie grants A.
REQ-032 Random a_in/b_in for 200 cycles -> gnt_a and gnt_b never both high, c_ou always followed by d_ou after 1 cycle, e_ou low while any grant is high.

Source files
------------

// File: rtl/seq_arbiter.sv
// seq_arbiter: two-requester arbiter that runs a START/ACTIVE/DONE
// transaction for the winner, with round-robin tie-breaking.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   a_in, b_in     level requests from requesters A and B
//   c_ou           one-cycle start strobe
//   d_ou           active phase, high for HOLD cycles
//   e_ou           idle indicator
//   gnt_a, gnt_b   one-hot owner of the current transaction
//   cnt_ou         remaining active cycles, 0 outside ACTIVE
//
// Config macro SEQ_ARB_FIXED_PRIO_EN: when defined, ties always go
// to A and no round-robin pointer is kept.

module seq_arbiter #(
    parameter int unsigned HOLD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_in,
    input  logic       b_in,
    output logic       c_ou,
    output logic       d_ou,
    output logic       e_ou,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [3:0] cnt_ou
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        ACTIVE,
        DONE
    } state_t;

    localparam logic [3:0] HOLD_V = 4'(HOLD);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ga_q, ga_d;
    logic       gb_q, gb_d;
    logic       pick_b;

`ifdef SEQ_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_b = b_in & ~a_in;
    end
`else
    // Set when B should win the next tie (A won the last transaction).
    logic prio_b_q, prio_b_d;

    always_comb begin
        pick_b = b_in & (~a_in | prio_b_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_b_q <= 1'b0;
        else        prio_b_q <= prio_b_d;
    end

    always_comb begin
        prio_b_d = prio_b_q;
        if (state_q == DONE) prio_b_d = ga_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ga_q    <= 1'b0;
            gb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ga_q    <= ga_d;
            gb_q    <= gb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ga_d    = ga_q;
        gb_d    = gb_q;
        case (state_q)
            IDLE: begin
                if (a_in | b_in) begin
                    state_d = START;
                    ga_d    = ~pick_b;
                    gb_d    = pick_b;
                end
            end
            START: begin
                state_d = ACTIVE;
                cnt_d   = HOLD_V;
            end
            ACTIVE: begin
                // Reaches 0 on the edge into DONE.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                ga_d    = 1'b0;
                gb_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                ga_d    = 1'b0;
                gb_d    = 1'b0;
            end
        endcase
    end

    assign c_ou   = (state_q == START);
    assign d_ou   = (state_q == ACTIVE);
    assign e_ou   = (state_q == IDLE);
    assign gnt_a  = ga_q;
    assign gnt_b  = gb_q;
    assign cnt_ou = cnt_q;

endmodule

// File: tb/tb_seq_arbiter.sv
// tb_seq_arbiter: random and directed requests against a transaction
// model; a monitor checks each start and the phases that follow it.

module tb_seq_arbiter;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       c_ou, d_ou, e_ou, gnt_a, gnt_b;
    logic [3:0] cnt_ou;

    seq_arbiter #(.HOLD(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_ou  (c_ou),
        .d_ou  (d_ou),
        .e_ou  (e_ou),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .cnt_ou(cnt_ou)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit win_b;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Model: edges still owned by the running transaction, and who won last.
    int   busy = 0;
    bit   last_was_a = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One call per rising edge: the inputs set here are sampled there.
    task automatic drive(input bit a, input bit b);
        exp_t e;
        bit   wb;
        @(negedge clk);
        a_in = a;
        b_in = b;
        if (busy > 0) begin
            busy--;
        end else if (a || b) begin
`ifdef SEQ_ARB_FIXED_PRIO_EN
            wb = b && !a;
`else
            wb = b && (!a || last_was_a);
`endif
            e.cyc   = cyc + 1;
            e.win_b = wb;
            exp_q.push_back(e);
            last_was_a = !wb;
            busy = HOLD + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    // Monitor: phase 0 = idle, 1..HOLD = active, HOLD+1 = done.
    int ph = 0;
    bit held_b = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph = 0;
        end else begin
            chk("onehot", int'(gnt_a && gnt_b), 0);
            if (gnt_a || gnt_b) chk("e_while_gnt", int'(e_ou), 0);
            if (ph >= 1 && ph <= HOLD) begin
                chk("act_d", int'(d_ou), 1);
                chk("act_c", int'(c_ou), 0);
                chk("act_cnt", int'(cnt_ou), HOLD - ph + 1);
                chk("act_gnt_b", int'(gnt_b), int'(held_b));
                chk("act_gnt_a", int'(gnt_a), int'(!held_b));
                ph++;
            end else if (ph == HOLD + 1) begin
                chk("done_cde", {c_ou, d_ou, e_ou}, 0);
                chk("done_cnt", int'(cnt_ou), 0);
                chk("done_gnt_b", int'(gnt_b), int'(held_b));
                chk("done_gnt_a", int'(gnt_a), int'(!held_b));
                ph = 0;
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("start_c", int'(c_ou), 1);
                chk("start_e", int'(e_ou), 0);
                chk("start_gnt_b", int'(gnt_b), int'(exp_q[0].win_b));
                chk("start_gnt_a", int'(gnt_a), int'(!exp_q[0].win_b));
                held_b = exp_q[0].win_b;
                void'(exp_q.pop_front());
                ph = 1;
            end else begin
                chk("idle_e", int'(e_ou), 1);
                chk("idle_cd", {c_ou, d_ou}, 0);
                chk("idle_gnt", {gnt_a, gnt_b}, 0);
                chk("idle_cnt", int'(cnt_ou), 0);
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single pulse from A.
        drive(1'b1, 1'b0);
        idle(7);

        // Both held: alternating grants.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);
        idle(7);

        // B pulse, then A during B's active phase.
        drive(1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0);
        idle(7);

        // Reset during the last active cycle.
        drive(1'b1, 1'b0);
        n = 0;
        while (cnt_ou != 4'd1 && n < 20) begin
            drive(1'b0, 1'b0);
            n++;
        end
        chk("wait_cnt1", n < 20 ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        busy = 0;
        last_was_a = 1'b0;
        #1;
        chk("rst_c", int'(c_ou), 0);
        chk("rst_d", int'(d_ou), 0);
        chk("rst_e", int'(e_ou), 1);
        chk("rst_gnt_a", int'(gnt_a), 0);
        chk("rst_gnt_b", int'(gnt_b), 0);
        chk("rst_cnt", int'(cnt_ou), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1);
        idle(7);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(8);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
